// File: rtl/kf_frame_sched_pkg.sv
// kf_frame_sched_pkg: shared widths, frame timing constants and scheduler state encoding
package kf_frame_sched_pkg;
  localparam int FXP_N = 20;
  localparam int FXP_FRAC = 10;
  localparam int KF_FRAME_CYCLES = 36;
  localparam int KF_TIMEOUT_DEFAULT = KF_FRAME_CYCLES + 4;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;
endpackage

// File: rtl/kf_ch_state_bank.sv
// kf_ch_state_bank: per-channel 2-word posterior store, one comb read port, one write port, sync clear-all
module kf_ch_state_bank #(
  parameter int N = 20,
  parameter int CH = 4,
  parameter int CHW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           we,
  input  logic [CHW-1:0] wch,
  input  logic [N-1:0]   wd00,
  input  logic [N-1:0]   wd10,
  input  logic [CHW-1:0] rch,
  output logic [N-1:0]   rd00,
  output logic [N-1:0]   rd10
);
  logic [N-1:0] x00_q [CH];
  logic [N-1:0] x10_q [CH];
  logic [N-1:0] x00_d [CH];
  logic [N-1:0] x10_d [CH];
  // clear beats write; only the addressed channel takes the write
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      x00_d[c] = clr ? '0 : (we && wch == CHW'(c)) ? wd00 : x00_q[c];
      x10_d[c] = clr ? '0 : (we && wch == CHW'(c)) ? wd10 : x10_q[c];
    end
  end
  // channel state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x00_q <= '{default: '0};
      x10_q <= '{default: '0};
    end else begin
      x00_q <= x00_d;
      x10_q <= x10_d;
    end
  end
  assign rd00 = x00_q[rch];
  assign rd10 = x10_q[rch];
endmodule

// File: rtl/kf_frame_sched.sv
// kf_frame_sched: time-multiplexes one top_kf core across CH channels with posterior feedback; KF_SCHED_LATSTAT_EN adds latency stats
module kf_frame_sched
  import kf_frame_sched_pkg::*;
#(
  parameter int N = FXP_N,
  parameter int FRAC = FXP_FRAC,
  parameter int CH = 4,
  parameter int CHW = (CH > 1) ? $clog2(CH) : 1,
  parameter int TIMEOUT = KF_TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [N-1:0]   in_u00,
  input  logic [N-1:0]   in_z00,
  input  logic [N-1:0]   in_z10,
  input  logic           clr_all,
  output logic           core_start,
  output logic [N-1:0]   core_x00_prev,
  output logic [N-1:0]   core_x10_prev,
  output logic [N-1:0]   core_u00,
  output logic [N-1:0]   core_z00,
  output logic [N-1:0]   core_z10,
  input  logic           core_done,
  input  logic [N-1:0]   core_X00_post,
  input  logic [N-1:0]   core_X10_post,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [N-1:0]   out_x00,
  output logic [N-1:0]   out_x10,
  output logic           out_err,
  output logic           err_badch
`ifdef KF_SCHED_LATSTAT_EN
  ,
  output logic [7:0]     lat_last,
  output logic [7:0]     lat_max
`endif
);
  // FRAC only documents the Q format of the pass-through words
  if (FRAC > N) begin : g_frac_exceeds_width
  end
  state_t state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d, och_q, och_d;
  logic [N-1:0] u_q, u_d, z0_q, z0_d, z1_q, z1_d;
  logic [N-1:0] px00_q, px00_d, px10_q, px10_d, cu_q, cu_d, cz0_q, cz0_d, cz1_q, cz1_d;
  logic [N-1:0] ox00_q, ox00_d, ox10_q, ox10_d;
  logic [7:0] cnt_q, cnt_d;
  logic ov_q, ov_d, oerr_q, oerr_d, badch_q, badch_d;
  logic clr, we;
  logic [N-1:0] rd00, rd10;
`ifdef KF_SCHED_LATSTAT_EN
  logic [7:0] lat_last_q, lat_last_d, lat_max_q, lat_max_d;
`endif
  kf_ch_state_bank #(.N(N), .CH(CH), .CHW(CHW)) u_bank (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wch(ch_q),
    .wd00(core_X00_post), .wd10(core_X10_post),
    .rch(ch_q), .rd00(rd00), .rd10(rd10)
  );
  // frame sequencing: accept, load prior, start core, wait for done or timeout, hold result
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    u_d = u_q;
    z0_d = z0_q;
    z1_d = z1_q;
    px00_d = px00_q;
    px10_d = px10_q;
    cu_d = cu_q;
    cz0_d = cz0_q;
    cz1_d = cz1_q;
    cnt_d = cnt_q;
    ov_d = ov_q;
    och_d = och_q;
    ox00_d = ox00_q;
    ox10_d = ox10_q;
    oerr_d = oerr_q;
    badch_d = 1'b0;
    clr = 1'b0;
    we = 1'b0;
`ifdef KF_SCHED_LATSTAT_EN
    lat_last_d = lat_last_q;
    lat_max_d = lat_max_q;
`endif
    case (state_q)
      S_IDLE: begin
        clr = clr_all;
`ifdef KF_SCHED_LATSTAT_EN
        lat_last_d = clr_all ? '0 : lat_last_q;
        lat_max_d = clr_all ? '0 : lat_max_q;
`endif
        if (!clr_all && in_valid) begin
          if (32'(in_ch) >= CH) badch_d = 1'b1;
          else begin
            ch_d = in_ch;
            u_d = in_u00;
            z0_d = in_z00;
            z1_d = in_z10;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        px00_d = rd00;
        px10_d = rd10;
        cu_d = u_q;
        cz0_d = z0_q;
        cz1_d = z1_q;
        state_d = S_START;
      end
      S_START: begin
        cnt_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (core_done) begin
          we = 1'b1;
          ox00_d = core_X00_post;
          ox10_d = core_X10_post;
          oerr_d = 1'b0;
          ov_d = 1'b1;
          och_d = ch_q;
          state_d = S_OUT;
`ifdef KF_SCHED_LATSTAT_EN
          lat_last_d = cnt_q + 8'd1;
          lat_max_d = (cnt_q + 8'd1 > lat_max_q) ? cnt_q + 8'd1 : lat_max_q;
`endif
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          ox00_d = px00_q;
          ox10_d = px10_q;
          oerr_d = 1'b1;
          ov_d = 1'b1;
          och_d = ch_q;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        ov_d = out_ready ? 1'b0 : ov_q;
        state_d = out_ready ? S_IDLE : S_OUT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // scheduler registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q <= '0;
      u_q <= '0;
      z0_q <= '0;
      z1_q <= '0;
      px00_q <= '0;
      px10_q <= '0;
      cu_q <= '0;
      cz0_q <= '0;
      cz1_q <= '0;
      cnt_q <= '0;
      ov_q <= 1'b0;
      och_q <= '0;
      ox00_q <= '0;
      ox10_q <= '0;
      oerr_q <= 1'b0;
      badch_q <= 1'b0;
`ifdef KF_SCHED_LATSTAT_EN
      lat_last_q <= '0;
      lat_max_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      u_q <= u_d;
      z0_q <= z0_d;
      z1_q <= z1_d;
      px00_q <= px00_d;
      px10_q <= px10_d;
      cu_q <= cu_d;
      cz0_q <= cz0_d;
      cz1_q <= cz1_d;
      cnt_q <= cnt_d;
      ov_q <= ov_d;
      och_q <= och_d;
      ox00_q <= ox00_d;
      ox10_q <= ox10_d;
      oerr_q <= oerr_d;
      badch_q <= badch_d;
`ifdef KF_SCHED_LATSTAT_EN
      lat_last_q <= lat_last_d;
      lat_max_q <= lat_max_d;
`endif
    end
  end
  assign in_ready = state_q == S_IDLE;
  assign core_start = state_q == S_START;
  assign core_x00_prev = px00_q;
  assign core_x10_prev = px10_q;
  assign core_u00 = cu_q;
  assign core_z00 = cz0_q;
  assign core_z10 = cz1_q;
  assign out_valid = ov_q;
  assign out_ch = och_q;
  assign out_x00 = ox00_q;
  assign out_x10 = ox10_q;
  assign out_err = oerr_q;
  assign err_badch = badch_q;
`ifdef KF_SCHED_LATSTAT_EN
  assign lat_last = lat_last_q;
  assign lat_max = lat_max_q;
`endif
endmodule

// File: tb/tb_kf_frame_sched.sv
// tb_kf_frame_sched: scoreboard bench with a top_kf response model driving multi-channel frames
module tb_kf_frame_sched;
  localparam int N = 20;
  localparam int CH = 3;
  localparam int CHW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, clr_all = 1'b0;
  logic [CHW-1:0] in_ch = '0, out_ch;
  logic [N-1:0] in_u00 = '0, in_z00 = '0, in_z10 = '0;
  logic core_start, core_done = 1'b0, out_valid, out_ready = 1'b0, out_err, err_badch;
  logic [N-1:0] core_x00_prev, core_x10_prev, core_u00, core_z00, core_z10;
  logic [N-1:0] core_X00_post = '0, core_X10_post = '0, out_x00, out_x10;
  typedef struct {
    logic [CHW-1:0] ch;
    logic [N-1:0] x00;
    logic [N-1:0] x10;
    logic err;
  } exp_t;
  exp_t sb[$];
  logic [N-1:0] m00 [CH];
  logic [N-1:0] m10 [CH];
  int n_cmp = 0, n_bad = 0, n_start = 0, n_badch = 0;

  kf_frame_sched #(.N(N), .FRAC(10), .CH(CH), .TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_u00(in_u00), .in_z00(in_z00), .in_z10(in_z10), .clr_all(clr_all),
    .core_start(core_start), .core_x00_prev(core_x00_prev), .core_x10_prev(core_x10_prev),
    .core_u00(core_u00), .core_z00(core_z00), .core_z10(core_z10), .core_done(core_done),
    .core_X00_post(core_X00_post), .core_X10_post(core_X10_post), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch), .out_x00(out_x00), .out_x10(out_x10),
    .out_err(out_err), .err_badch(err_badch)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (core_start) n_start++;
    if (err_badch) n_badch++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m00[c] = '0;
      m10[c] = '0;
    end
  endtask

  task automatic frame(input int ch, input logic [N-1:0] u, input logic [N-1:0] z0,
                       input logic [N-1:0] z1, input logic [N-1:0] p00, input logic [N-1:0] p10,
                       input bit respond, input int hold);
    exp_t e;
    int k;
    logic [N-1:0] h00;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_ch = CHW'(ch);
    in_u00 = u;
    in_z00 = z0;
    in_z10 = z1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("start_early", core_start, 0);
    @(negedge clk);
    chk("start_lat2", core_start, 1);
    chk("x00_prev", core_x00_prev, m00[ch]);
    chk("x10_prev", core_x10_prev, m10[ch]);
    chk("core_u00", core_u00, u);
    chk("core_z00", core_z00, z0);
    chk("core_z10", core_z10, z1);
    e.ch = CHW'(ch);
    e.x00 = respond ? p00 : m00[ch];
    e.x10 = respond ? p10 : m10[ch];
    e.err = !respond;
    sb.push_back(e);
    if (respond) begin
      m00[ch] = p00;
      m10[ch] = p10;
      repeat (36) @(negedge clk);
      chk("no_out_before_done", out_valid, 0);
      core_done = 1'b1;
      core_X00_post = p00;
      core_X10_post = p10;
      @(negedge clk);
      core_done = 1'b0;
      core_X00_post = $urandom_range(0, 1 << 19);
      chk("done_to_valid", out_valid, 1);
    end else begin
      k = 0;
      while (!out_valid && k < 60) begin
        @(negedge clk);
        k++;
      end
      chk("timeout_cycles", k, 41);
    end
    if (sb.size() == 0) chk("sb_underflow", 1, 0);
    else begin
      e = sb.pop_front();
      chk("out_ch", out_ch, e.ch);
      chk("out_x00", out_x00, e.x00);
      chk("out_x10", out_x10, e.x10);
      chk("out_err", out_err, e.err);
    end
    h00 = out_x00;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_x00", out_x00, h00);
      chk("bp_x10", out_x10, e.x10);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("idle_after_out", in_ready, 1);
  endtask

  initial begin
    int s;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_x00_prev", core_x00_prev, 0);
    chk("rst_badch", err_badch, 0);
    rst = 1'b0;
    frame(0, 20'h00400, 20'h00100, 20'h00000, 20'h00200, 20'hFFC00, 1, 0);
    frame(1, 20'h00123, 20'h00050, 20'hFFF80, 20'h12345, 20'h00ABC, 1, 0);
    frame(0, 20'h00010, 20'h00020, 20'h00030, 20'h00300, 20'h00010, 1, 0);
    frame(1, 20'h00777, 20'h00011, 20'h00022, 20'h0F0F0, 20'h80001, 1, 0);
    frame(1, 20'h00001, 20'h00002, 20'h00003, 20'h00000, 20'h00000, 0, 0);
    frame(1, 20'h00004, 20'h00005, 20'h00006, 20'h55555, 20'hAAAAA, 1, 0);
    frame(2, 20'h00100, 20'h00200, 20'h00300, 20'h7FFFF, 20'h00001, 1, 10);
    s = n_start;
    @(negedge clk);
    in_valid = 1'b1;
    in_ch = 2'd3;
    @(negedge clk);
    in_valid = 1'b0;
    chk("badch_pulse", err_badch, 1);
    chk("badch_stay_idle", in_ready, 1);
    @(negedge clk);
    chk("badch_one_cycle", err_badch, 0);
    repeat (3) @(negedge clk);
    chk("badch_no_start", n_start, s);
    chk("badch_count", n_badch, 1);
    clr_all = 1'b1;
    in_valid = 1'b1;
    in_ch = 2'd1;
    @(negedge clk);
    clr_all = 1'b0;
    in_valid = 1'b0;
    chk("clr_wins_idle", in_ready, 1);
    repeat (3) @(negedge clk);
    chk("clr_no_start", n_start, s);
    model_clear();
    for (int c = 0; c < CH; c++)
      frame(c, 20'(c + 1), 20'(c + 2), 20'(c + 3), 20'(20'h01000 * (c + 1)), 20'(20'h00077 + c), 1, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_ch = 2'd2;
    in_u00 = 20'h00999;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstw_start", core_start, 1);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_out_valid", out_valid, 0);
    chk("rstw_idle", in_ready, 1);
    chk("rstw_x00_prev", core_x00_prev, 0);
    core_done = 1'b1;
    core_X00_post = 20'h0BEEF;
    core_X10_post = 20'h0CAFE;
    @(negedge clk);
    core_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstw_no_out", out_valid, 0);
    model_clear();
    for (int c = 0; c < CH; c++)
      frame(c, 20'h00011, 20'h00022, 20'h00033, 20'(20'h00400 + c), 20'(20'hFF000 - c), 1, 0);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/kf_frame_sched.md
Name: kf_frame_sched

Overview:
- Closed-loop frame scheduler in front of one top_kf core, time-multiplexing it across CH independent 2-state filter channels.
- Accepts measurement/input tuples on a valid/ready stream and loads the channel's stored posterior as x_prev.
- Pulses start and waits for done with a timeout, then writes the posterior back and emits it on an output stream.
- Replaces bench-side feedback of X_post into x_prev with RTL, for multi-channel and multi-frame operation.

Parameters:
- N, 20, fixed-point word width (Q(N,FRAC), two's complement).
- FRAC, 10, fractional bits; pass-through only, no arithmetic depends on it.
- CH, 4, number of filter channels (2..16).
- CHW, $clog2(CH) (min 1), channel-id width.
- TIMEOUT, 40, maximum WAIT cycles before abort (frame length 36 plus 4 margin).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  tuple valid.
- in_ready  out  1  high only in IDLE.
- in_ch  in  CHW  channel id.
- in_u00, in_z00, in_z10  in  N each  input current, measurements.
- clr_all  in  1  zero all channel states; honoured only in IDLE.
- core_start  out  1  one-cycle start pulse to top_kf.
- core_x00_prev, core_x10_prev, core_u00, core_z00, core_z10  out  N each  registered, held stable from LOAD until the next LOAD.
- core_done  in  1  top_kf done.
- core_X00_post, core_X10_post  in  N each  posterior from top_kf.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream ready.
- out_ch  out  CHW  result channel.
- out_x00, out_x10  out  N each  posterior (or the unchanged prior on abort).
- out_err  out  1  frame aborted by timeout.
- err_badch  out  1  one-cycle pulse when an in_ch >= CH is dropped.

Behaviour:
- Reset (synchronous on rst):
  - state IDLE; all outputs and core_* registers 0; channel state regs (x00[c], x10[c]) 0; timeout counter 0.
  - rst mid-frame aborts with no write-back and no output. The bench must also reset top_kf.
- FSM states: IDLE, LOAD, START, WAIT, OUT.
- IDLE:
  - Accept on in_valid & in_ready.
  - in_ch >= CH: tuple consumed, err_badch pulses the next cycle, stay IDLE.
  - Otherwise latch the tuple and go to LOAD.
  - clr_all & in_valid in the same cycle: clear wins; the tuple is not accepted (in_ready stays 1 but acceptance is suppressed).
- LOAD: core_x*_prev <= x*[ch]; core_u00/z00/z10 <= latched tuple. Next state START.
- START: core_start=1 for exactly one cycle; counter <= 0. Next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - core_done=1: x00[ch], x10[ch] <= core_X*_post; out_x* <= core_X*_post; out_err <= 0; out_valid <= 1; go OUT.
  - Else if counter == TIMEOUT-1: out_x* <= stored prior (no write-back); out_err <= 1; out_valid <= 1; go OUT.
  - done in the same cycle as the timeout hit: done wins.
- OUT: hold all out_* stable. On out_ready, out_valid <= 0 and go IDLE. Backpressure stalls indefinitely; core_done is ignored outside WAIT.
- Latency: accept edge to core_start high = 2 cycles. core_done to out_valid = 1 cycle. Back-to-back throughput = frame + 4 cycles when out_ready is tied high.
- No arithmetic on data words: pure storage and muxing. Widths are exact N; no truncation.
- Channels are fully independent. A channel's state changes only on its own successful frame, clr_all, or rst.

Optional Feature:
- Macro KF_SCHED_LATSTAT_EN.
- Defined: adds outputs lat_last (8 bits), the WAIT cycle count of the latest successful frame, and lat_max (8 bits), the sticky maximum. Both update at the same edge as out_valid rises; both are cleared by rst and by clr_all.
- Undefined: ports absent, no counters beyond the timeout counter.

Decomposition:
- Shared package/include (alongside fxp_types.vh):
  - FXP_N/FXP_FRAC defaults.
  - State encoding localparams (IDLE=0, LOAD=1, START=2, WAIT=3, OUT=4).
  - KF_FRAME_CYCLES=36 and KF_TIMEOUT_DEFAULT=40.
- One sub-module: kf_ch_state_bank. CH x 2 x N register file with one read port (combinational by ch), one write port, and synchronous clear-all.

Test Plan:
- Single frame:
  - Stimulus: ch0, u00=fxp(1.0), z=(fxp(0.25),0); core model asserts done 36 cycles after start with X_post=(0x00200,0xFFC00).
  - Required: core_start 2 cycles after accept; core_x*_prev=0; out_valid 1 cycle after done with out_ch=0, out_x=(0x00200,0xFFC00), out_err=0.
- Channel isolation:
  - Stimulus: frames ch1 then ch0 then ch1.
  - Required: the second ch1 frame presents x_prev equal to ch1's first posterior; ch0's first frame presents x_prev=0.
- Timeout:
  - Stimulus: core never asserts done.
  - Required: out_valid at WAIT count 40 with out_err=1 and out_x equal to the prior; the next frame on that channel reloads the same prior.
- Backpressure:
  - Stimulus: out_ready low for 10 cycles after out_valid.
  - Required: out_* stable for those 10 cycles, in_ready=0; IDLE the cycle after out_ready rises.
- Bad channel / clear:
  - Stimulus: in_ch=CH.
  - Required: err_badch pulses once, no core_start.
  - Stimulus: clr_all in IDLE.
  - Required: every channel's next x_prev reads 0.
- Reset mid-WAIT:
  - Stimulus: rst for 1 cycle at WAIT count 10.
  - Required: state IDLE, out_valid=0, all channel states 0, no write-back.
